// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, aligns and extends load data,
// and keeps the SRAM read data stable while write-back is stalled.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         exe_mem_valid,
  output logic         mem_allowin,
  input  logic [105:0] exe_mem_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic         mem_wb_valid,
  input  logic         wb_allowin,
  output logic [101:0] mem_wb_bus,
  output logic [37:0]  mem_fwd_bus
);

  typedef enum logic [2:0] {
    OP_LD_W  = 3'b000,
    OP_LD_B  = 3'b001,
    OP_LD_H  = 3'b010,
    OP_LD_BU = 3'b011,
    OP_LD_HU = 3'b100
  } mem_op_e;

  localparam logic ready_go = 1'b1;

  logic         mem_valid;
  logic [105:0] bus_r;
  logic         held;
  logic [31:0]  rdata_buf;

  logic         gr_we;
  logic         res_from_mem;
  logic [2:0]   mem_op;
  logic [4:0]   dest;
  logic [31:0]  pc;
  logic [31:0]  inst;
  logic [31:0]  alu_result;

  logic [31:0]  rdata_eff;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [31:0]  load_data;
  logic [31:0]  final_result;

  assign {gr_we, res_from_mem, mem_op, dest, pc, inst, alu_result} = bus_r;

  assign mem_allowin  = ~mem_valid | (wb_allowin & ready_go);
  assign mem_wb_valid = mem_valid & ready_go;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      bus_r     <= '0;
    end else begin
      if (mem_allowin) begin
        mem_valid <= exe_mem_valid;
      end
      if (exe_mem_valid && mem_allowin) begin
        bus_r <= exe_mem_bus;
      end
    end
  end

  // SRAM data is only valid for one cycle; freeze it for the rest of a stall.
  // Leaving the stage always wins over capturing.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      held      <= 1'b0;
      rdata_buf <= '0;
    end else if (mem_allowin) begin
      held <= 1'b0;
    end else if (mem_valid && !wb_allowin && !held) begin
      held      <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  assign rdata_eff = held ? rdata_buf : data_sram_rdata;

  always_comb begin
    byte_sel = 8'h00;
    case (alu_result[1:0])
      2'b00: byte_sel = rdata_eff[7:0];
      2'b01: byte_sel = rdata_eff[15:8];
      2'b10: byte_sel = rdata_eff[23:16];
      2'b11: byte_sel = rdata_eff[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = alu_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];
  end

  // Unassigned encodings fall back to a full-word load.
  always_comb begin
    load_data = rdata_eff;
    case (mem_op)
      OP_LD_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LD_H:  load_data = {{16{half_sel[15]}}, half_sel};
      OP_LD_BU: load_data = {24'h000000, byte_sel};
      OP_LD_HU: load_data = {16'h0000, half_sel};
      default:  load_data = rdata_eff;
    endcase
  end

  assign final_result = res_from_mem ? load_data : alu_result;

  assign mem_wb_bus  = {gr_we, dest, pc, inst, final_result};
  assign mem_fwd_bus = {mem_valid & gr_we, dest, final_result};

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL: exe_mem_valid  input  1  upstream instruction valid.
REQ-004 SHALL: mem_allowin  output  1  stage can accept an instruction this cycle.
REQ-005 SHALL: exe_mem_bus  input  106  packed, MSB first: {gr_we[1], res_from_mem[1], mem_op[3], dest[5], pc[32], inst[32], alu_result[32]}.
REQ-006 SHALL: data_sram_rdata  input  32  synchronous SRAM read data; valid the cycle after the address was presented.
REQ-007 SHALL: mem_wb_valid  output  1  instruction valid toward write-back.
REQ-008 SHALL: wb_allowin  input  1  write-back can accept.
REQ-009 SHALL: mem_wb_bus  output  102  packed, MSB first: {gr_we, dest[5], pc[32], inst[32], final_result[32]}.
REQ-010 SHALL: mem_fwd_bus  output  38  {fwd_we, dest[5], final_result[32]}, used for hazard/forwarding in decode.

Function
REQ-011 SHALL: hold a valid register mem_valid and a 106-bit bus register; ready_go is constant 1.
REQ-012 SHALL: mem_allowin = ~mem_valid | (wb_allowin & ready_go); mem_wb_valid = mem_valid & ready_go.
REQ-013 SHALL: when mem_allowin=1, mem_valid <= exe_mem_valid on each edge.
REQ-014 SHALL: load the bus register only when exe_mem_valid & mem_allowin; otherwise hold it.
REQ-015 SHALL: latency one cycle: an instruction accepted at edge N is presented on mem_wb_bus from N until it is accepted downstream.
REQ-016 SHALL: rdata hold buffer: when mem_valid & ~wb_allowin & ~held, capture data_sram_rdata into rdata_buf and set held=1.
REQ-017 SHALL: clear held on any edge where mem_allowin=1; clear takes priority over set in the same cycle.
REQ-018 SHALL: effective rdata = held ? rdata_buf : data_sram_rdata.
REQ-019 SHALL: mem_op decode: 000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu; 101-111 treated as ld.w.
REQ-020 SHALL: byte select by alu_result[1:0] (00 bits 7:0 .. 11 bits 31:24); halfword select by alu_result[1] (0 bits 15:0, 1 bits 31:16).
REQ-021 SHALL: ld.b/ld.h sign-extend to 32 bits; ld.bu/ld.hu zero-extend; ld.w passes all 32 bits; misalignment is not checked.
REQ-022 SHALL: final_result = res_from_mem ? load_data : alu_result.
REQ-023 SHALL: mem_wb_bus gr_we field = bus gr_we (unqualified); validity conveyed by mem_wb_valid.
REQ-024 SHALL: fwd_we = mem_valid & gr_we; fwd_we=0 whenever mem_valid=0.
REQ-025 SHALL: simultaneous drain and fill (mem_valid=1, wb_allowin=1, exe_mem_valid=1) replace the instruction with no bubble.
REQ-026 SHALL: when upstream is invalid and mem_allowin=1, mem_valid goes 0 and the bus register keeps its old value.

Reset
REQ-027 SHALL: on resetn=0 at an edge: mem_valid=0, held=0, rdata_buf=0, bus register=0.
REQ-028 SHALL: outputs after reset: mem_allowin=1, mem_wb_valid=0, mem_fwd_bus=0, mem_wb_bus=0.
REQ-029 SHALL: reset mid-stall discards the held instruction and buffered rdata; no output from before reset appears afterwards.

Verification
REQ-030 SHALL: ld.b, alu_result=0x1003, rdata=0x80FF1234, res_from_mem=1 -> final_result=0xFFFFFF80, mem_wb_valid=1 one cycle after accept.
REQ-031 SHALL: ld.hu, alu_result=0x0002, rdata=0x8001ABCD -> final_result=0x00008001; ld.h same inputs -> 0xFFFF8001.
REQ-032 SHALL: load accepted, wb_allowin=0 for 3 cycles while rdata changes to 0xDEADBEEF -> mem_wb_bus final_result stays the original value; mem_allowin=0 throughout; released on wb_allowin=1.
REQ-033 SHALL: back-to-back ALU ops (res_from_mem=0, results 0x11, 0x22, 0x33) with wb_allowin=1 -> three consecutive mem_wb_valid cycles with results in order, no bubbles.
REQ-034 SHALL: gr_we=1, dest=5, mem_valid=1 -> mem_fwd_bus={1,5,result}; mem_valid=0 -> fwd_we=0.
REQ-035 SHALL: resetn=0 during a stall -> next cycle mem_wb_valid=0, mem_allowin=1, held=0.
